mem_xfer_sched: RTL and testbench

- Transfer sequencer between the 8 KiB-line on-chip vault BRAM port and the 24-bit AXI-Lite external memory bus.
- Accepts one block-copy command at a time in either direction (BRAM->AXI store, AXI->BRAM load) and moves it as single-beat 512-bit lines.
- Drives the BRAM port and the AXI-Lite master channels itself; sits under the key-storage logic in place of hand-sequenced accesses.

---
 rtl/mem_xfer_sched_if.sv | 44 ++++
 rtl/mem_xfer_sched.sv | 142 ++++++++++++++
 tb/tb_mem_xfer_sched.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_xfer_sched_if.sv
// Bundled command, status, BRAM port and AXI-Lite master channels of mem_xfer_sched.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface mem_xfer_sched_if #(
    parameter int BRAM_AW = 13,
    parameter int AXI_AW  = 24,
    parameter int DATA_W  = 512,
    parameter int LEN_W   = 14
) ();
    logic               cmd_valid, cmd_ready, cmd_dir;
    logic [BRAM_AW-1:0] cmd_bram_addr;
    logic [AXI_AW-1:0]  cmd_axi_addr;
    logic [LEN_W-1:0]   cmd_len;
    logic               done, err, busy;
    logic               we;
    logic [BRAM_AW-1:0] addr;
    logic [DATA_W-1:0]  dout, din;
    logic [AXI_AW-1:0]  araddr, awaddr;
    logic               arvalid, arready, rvalid, rready;
    logic               awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0]  rdata, wdata;
    logic [1:0]         rresp, bresp;

    modport master (
        input  cmd_valid, cmd_dir, cmd_bram_addr, cmd_axi_addr, cmd_len,
        output cmd_ready, done, err, busy,
        output we, addr, dout, input din,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        output cmd_valid, cmd_dir, cmd_bram_addr, cmd_axi_addr, cmd_len,
        input  cmd_ready, done, err, busy,
        input  we, addr, dout, output din,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/mem_xfer_sched.sv
// Line-by-line block copy between the vault BRAM port and an AXI-Lite memory bus.
// Define MEM_XFER_ERR_ABORT_EN to end a command on its first non-OKAY response.
module mem_xfer_sched #(
    parameter int BRAM_AW = 13,
    parameter int AXI_AW  = 24,
    parameter int DATA_W  = 512,
    parameter int LEN_W   = 14
) (
    input logic clk_i,
    input logic rst_i,
    mem_xfer_sched_if.master bus
);
    localparam int STRIDE_SH = $clog2(DATA_W / 8);

    typedef enum logic [3:0] {
        S_IDLE, S_BRD, S_BWAIT, S_AW_W, S_B, S_AR, S_R, S_BWR, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               dir_q;
    logic [BRAM_AW-1:0] bram_q;
    logic [AXI_AW-1:0]  axi_q, axi_line;
    logic [LEN_W-1:0]   len_q, idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d, dout_q, dout_d;
    logic               aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d;
    logic               cmd_acc, last_line, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign cmd_acc   = (state_q == S_IDLE) && bus.cmd_valid;
    assign last_line = (idx_q + LEN_W'(1)) == len_q;
    assign axi_line  = axi_q + (AXI_AW'(idx_q) << STRIDE_SH);
    assign aw_hs     = bus.awvalid && bus.awready;
    assign w_hs      = bus.wvalid && bus.wready;
    assign b_hs      = bus.bvalid && bus.bready;
    assign ar_hs     = bus.arvalid && bus.arready;
    assign r_hs      = bus.rvalid && bus.rready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wdata_q   <= '0;
            dout_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            dir_q     <= 1'b0;
            bram_q    <= '0;
            axi_q     <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            if (cmd_acc) begin
                dir_q  <= bus.cmd_dir;
                bram_q <= bus.cmd_bram_addr;
                axi_q  <= bus.cmd_axi_addr;
                len_q  <= bus.cmd_len;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                err_d = 1'b0;
                idx_d = '0;
                if (bus.cmd_len == '0) state_d = S_DONE;
                else                   state_d = bus.cmd_dir ? S_AR : S_BRD;
            end
            S_BRD:   state_d = S_BWAIT;
            S_BWAIT: begin
                // BRAM read data is valid one cycle after the address.
                wdata_d   = bus.din;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = S_AW_W;
            end
            S_AW_W: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_B;
            end
            S_B: if (b_hs) begin
                if (bus.bresp != 2'b00) err_d = 1'b1;
                if (last_line) state_d = S_DONE;
                else begin
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = S_BRD;
                end
`ifdef MEM_XFER_ERR_ABORT_EN
                if (bus.bresp != 2'b00) state_d = S_DONE;
`endif
            end
            S_AR: if (ar_hs) state_d = S_R;
            S_R: if (r_hs) begin
                dout_d  = bus.rdata;
                state_d = S_BWR;
                if (bus.rresp != 2'b00) err_d = 1'b1;
`ifdef MEM_XFER_ERR_ABORT_EN
                if (bus.rresp != 2'b00) state_d = S_DONE;
`endif
            end
            S_BWR: begin
                if (last_line) state_d = S_DONE;
                else begin
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = S_AR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.err       = err_q;
    assign bus.we        = (state_q == S_BWR);
    assign bus.addr      = bram_q + BRAM_AW'(idx_q);
    assign bus.dout      = dout_q;
    assign bus.araddr    = axi_line;
    assign bus.arvalid   = (state_q == S_AR);
    assign bus.rready    = (state_q == S_R);
    assign bus.awaddr    = axi_line;
    assign bus.awvalid   = (state_q == S_AW_W) && !aw_done_q;
    assign bus.wdata     = wdata_q;
    assign bus.wvalid    = (state_q == S_AW_W) && !w_done_q;
    assign bus.bready    = (state_q == S_B);
endmodule

// File: tb/tb_mem_xfer_sched.sv
// Randomized bench for mem_xfer_sched: BRAM/AXI-Lite slave models plus a
// transaction-list reference model derived from the copy rules.
module tb_mem_xfer_sched;
    localparam int BAW = 13, AAW = 24, DW = 512, LW = 14;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    mem_xfer_sched_if #(.BRAM_AW(BAW), .AXI_AW(AAW), .DATA_W(DW), .LEN_W(LW)) bus ();
    mem_xfer_sched #(.BRAM_AW(BAW), .AXI_AW(AAW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    int total = 0, bad = 0;

    // slave configuration, written only by the stimulus process
    int aw_delay = 0, w_delay = 0, err_line = -1;
    logic [31:0] salt = 32'h1234_5678;

    // observations, written only by the monitor
    int cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0;
    int b_hs_cnt = 0, wv_cyc = 0, aw_cyc = 0, act_cyc = 0, proto_bad = 0;
    logic [AAW-1:0] ar_q[$], aw_q[$];
    logic [DW-1:0]  w_q[$], wd_q[$];
    logic [BAW-1:0] wa_q[$];

    // expected transaction lists, built by the reference model
    logic [AAW-1:0] exp_ar[$], exp_aw[$];
    logic [DW-1:0]  exp_w[$], exp_wd[$];
    logic [BAW-1:0] exp_wa[$];
    logic           exp_err;

    function automatic logic [DW-1:0] bfun(input logic [BAW-1:0] a);
        return {16{salt ^ {19'd0, a}}};
    endfunction
    function automatic logic [DW-1:0] rfun(input logic [AAW-1:0] a);
        return {16{~salt ^ {8'hC3, a}}};
    endfunction

    // slave models and protocol monitor, all acting on the falling edge
    int aw_wait, w_wait, r_line, b_line;
    logic aw_got, w_got, b_pend, r_pend, aw_hold, w_hold, ar_hold;
    logic [AAW-1:0] r_addr, aw_hold_a, ar_hold_a;
    logic [DW-1:0]  rd_pipe, w_hold_d;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            aw_wait = 0; w_wait = 0; r_line = 0; b_line = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_hold = 0; w_hold = 0; ar_hold = 0; r_addr = '0; rd_pipe = '0;
            bus.din = '0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = 2'b00;
            bus.bvalid = 0; bus.bresp = 2'b00;
            bus.arready = 0; bus.awready = 0; bus.wready = 0;
        end else begin
            bus.din    = rd_pipe;
            rd_pipe    = bfun(bus.addr);
            bus.rvalid = r_pend;
            bus.rdata  = rfun(r_addr);
            bus.rresp  = (r_line == err_line) ? 2'b10 : 2'b00;
            bus.bvalid = b_pend;
            bus.bresp  = (b_line == err_line) ? 2'b10 : 2'b00;
            bus.arready = bus.arvalid;
            bus.awready = bus.awvalid && (aw_wait >= aw_delay);
            bus.wready  = bus.wvalid && (w_wait >= w_delay);
            if (bus.awvalid && !bus.awready) aw_wait++;
            if (bus.wvalid && !bus.wready) w_wait++;
            if (aw_hold && (!bus.awvalid || bus.awaddr !== aw_hold_a)) proto_bad++;
            if (w_hold && (!bus.wvalid || bus.wdata !== w_hold_d)) proto_bad++;
            if (ar_hold && (!bus.arvalid || bus.araddr !== ar_hold_a)) proto_bad++;
            aw_hold = bus.awvalid && !bus.awready; aw_hold_a = bus.awaddr;
            w_hold  = bus.wvalid && !bus.wready;   w_hold_d  = bus.wdata;
            ar_hold = bus.arvalid && !bus.arready; ar_hold_a = bus.araddr;
            if (bus.awvalid) aw_cyc++;
            if (bus.wvalid) wv_cyc++;
            if (bus.we || bus.arvalid || bus.awvalid || bus.wvalid) act_cyc++;
            if (bus.cmd_valid && bus.cmd_ready) begin acc_cyc = cyc; r_line = 0; b_line = 0; end
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (bus.we) begin wa_q.push_back(bus.addr); wd_q.push_back(bus.dout); end
            if (bus.rvalid && bus.rready) begin r_pend = 0; r_line++; end
            if (bus.arvalid && bus.arready) begin ar_q.push_back(bus.araddr); r_pend = 1; r_addr = bus.araddr; end
            if (bus.bvalid && bus.bready) begin b_pend = 0; b_hs_cnt++; b_line++; end
            if (bus.awvalid && bus.awready) begin aw_q.push_back(bus.awaddr); aw_got = 1; aw_wait = 0; end
            if (bus.wvalid && bus.wready) begin w_q.push_back(bus.wdata); w_got = 1; w_wait = 0; end
            if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
        end
    end

    // what a copy of len lines must produce on each bus
    task automatic build_model(input logic dir, input logic [BAW-1:0] b, input logic [AAW-1:0] a, input int len);
        exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_wa.delete(); exp_wd.delete();
        exp_err = 1'b0;
        for (int k = 0; k < len; k++) begin
            logic [AAW-1:0] ax;
            logic [BAW-1:0] bx;
            ax = a + AAW'(k * (DW / 8));
            bx = b + BAW'(k);
            if (!dir) begin
                exp_aw.push_back(ax);
                exp_w.push_back(bfun(bx));
            end else begin
                exp_ar.push_back(ax);
`ifndef MEM_XFER_ERR_ABORT_EN
                exp_wa.push_back(bx);
                exp_wd.push_back(rfun(ax));
`else
                if (k != err_line) begin
                    exp_wa.push_back(bx);
                    exp_wd.push_back(rfun(ax));
                end
`endif
            end
            if (k == err_line) begin
                exp_err = 1'b1;
`ifdef MEM_XFER_ERR_ABORT_EN
                break;
`endif
            end
        end
    endtask

    task automatic issue(input logic dir, input logic [BAW-1:0] b, input logic [AAW-1:0] a,
                         input logic [LW-1:0] len, output int lat, output logic ok);
        int d0;
        d0 = done_cnt;
        @(posedge clk); #2;
        bus.cmd_valid = 1'b1; bus.cmd_dir = dir; bus.cmd_bram_addr = b;
        bus.cmd_axi_addr = a; bus.cmd_len = len;
        @(posedge clk); #2;
        bus.cmd_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (done_cnt > d0) begin ok = 1'b1; break; end
        end
        lat = done_cyc - acc_cyc;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%0b exp=1", bus.cmd_ready); end
        total++; if ({bus.done, bus.busy, bus.err, bus.we, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 9'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0", {bus.done, bus.busy, bus.err, bus.we, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
        total++; if ({bus.addr, bus.araddr, bus.awaddr} !== '0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", {bus.addr, bus.araddr, bus.awaddr}); end
        total++; if ({bus.dout, bus.wdata} !== '0) begin bad++; $display("FAIL reset_data got=%0h exp=0", {bus.dout, bus.wdata}); end
        rst = 1'b0;
    endtask

    task automatic test_store_basic;
        int lat, a0, w0, b0; logic ok;
        err_line = -1;
        a0 = aw_q.size(); w0 = w_q.size(); b0 = b_hs_cnt;
        build_model(1'b0, 13'h0010, 24'h001000, 3);
        issue(1'b0, 13'h0010, 24'h001000, 14'd3, lat, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL store_timeout got=%0b exp=1", ok); end
        total++; if (lat !== 13) begin bad++; $display("FAIL store_latency got=%0d exp=13", lat); end
        total++; if (aw_q.size() - a0 !== 3 || w_q.size() - w0 !== 3) begin bad++; $display("FAIL store_count got=%0d/%0d exp=3", aw_q.size() - a0, w_q.size() - w0); end
        for (int k = 0; k < exp_aw.size(); k++) begin
            total++; if (aw_q[a0+k] !== exp_aw[k]) begin bad++; $display("FAIL store_awaddr%0d got=%0h exp=%0h", k, aw_q[a0+k], exp_aw[k]); end
            total++; if (w_q[w0+k] !== exp_w[k]) begin bad++; $display("FAIL store_wdata%0d got=%0h exp=%0h", k, w_q[w0+k], exp_w[k]); end
        end
        total++; if (b_hs_cnt - b0 !== 3) begin bad++; $display("FAIL store_bhs got=%0d exp=3", b_hs_cnt - b0); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL store_err got=%0b exp=0", bus.err); end
    endtask

    task automatic test_load_wrap;
        int lat, r0, x0; logic ok;
        err_line = -1;
        r0 = ar_q.size(); x0 = wa_q.size();
        build_model(1'b1, 13'h1FFF, 24'hFFFFC0, 2);
        issue(1'b1, 13'h1FFF, 24'hFFFFC0, 14'd2, lat, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL load_timeout got=%0b exp=1", ok); end
        total++; if (ar_q.size() - r0 !== 2 || wa_q.size() - x0 !== 2) begin bad++; $display("FAIL load_count got=%0d/%0d exp=2", ar_q.size() - r0, wa_q.size() - x0); end
        for (int k = 0; k < 2; k++) begin
            total++; if (ar_q[r0+k] !== exp_ar[k]) begin bad++; $display("FAIL load_araddr%0d got=%0h exp=%0h", k, ar_q[r0+k], exp_ar[k]); end
            total++; if (wa_q[x0+k] !== exp_wa[k]) begin bad++; $display("FAIL load_waddr%0d got=%0h exp=%0h", k, wa_q[x0+k], exp_wa[k]); end
            total++; if (wd_q[x0+k] !== exp_wd[k]) begin bad++; $display("FAIL load_wdat%0d got=%0h exp=%0h", k, wd_q[x0+k], exp_wd[k]); end
        end
    endtask

    task automatic test_len_zero;
        int lat, act0; logic ok;
        act0 = act_cyc;
        issue(1'b0, 13'h0123, 24'h00ABC0, 14'd0, lat, ok);
        total++; if (ok !== 1'b1 || lat !== 1) begin bad++; $display("FAIL len0_latency got=%0d exp=1", lat); end
        total++; if (act_cyc - act0 !== 0) begin bad++; $display("FAIL len0_activity got=%0d exp=0", act_cyc - act0); end
    endtask

    task automatic test_aw_delay;
        int lat, a0, w0, b0, wv0, av0, p0; logic ok;
        err_line = -1; aw_delay = 3; w_delay = 0; salt = $urandom;
        a0 = aw_q.size(); w0 = w_q.size(); b0 = b_hs_cnt; wv0 = wv_cyc; av0 = aw_cyc; p0 = proto_bad;
        build_model(1'b0, 13'h0ABC, 24'h123440, 3);
        issue(1'b0, 13'h0ABC, 24'h123440, 14'd3, lat, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL awdly_timeout got=%0b exp=1", ok); end
        total++; if (wv_cyc - wv0 !== 3) begin bad++; $display("FAIL awdly_wvalid_cycles got=%0d exp=3", wv_cyc - wv0); end
        total++; if (aw_cyc - av0 !== 12) begin bad++; $display("FAIL awdly_awvalid_cycles got=%0d exp=12", aw_cyc - av0); end
        total++; if (proto_bad - p0 !== 0) begin bad++; $display("FAIL awdly_stability got=%0d exp=0", proto_bad - p0); end
        total++; if (b_hs_cnt - b0 !== 3) begin bad++; $display("FAIL awdly_bhs got=%0d exp=3", b_hs_cnt - b0); end
        for (int k = 0; k < 3; k++) begin
            total++; if (aw_q[a0+k] !== exp_aw[k] || w_q[w0+k] !== exp_w[k]) begin
                bad++; $display("FAIL awdly_line%0d got=%0h exp=%0h", k, aw_q[a0+k], exp_aw[k]); end
        end
        aw_delay = 0;
    endtask

    task automatic test_load_err;
        int lat, x0; logic ok;
        err_line = 1;
        x0 = wa_q.size();
        build_model(1'b1, 13'h0200, 24'h004000, 4);
        issue(1'b1, 13'h0200, 24'h004000, 14'd4, lat, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL lderr_timeout got=%0b exp=1", ok); end
        total++; if (wa_q.size() - x0 !== exp_wa.size()) begin bad++; $display("FAIL lderr_writes got=%0d exp=%0d", wa_q.size() - x0, exp_wa.size()); end
        for (int k = 0; k < exp_wa.size(); k++) begin
            total++; if (wa_q[x0+k] !== exp_wa[k] || wd_q[x0+k] !== exp_wd[k]) begin
                bad++; $display("FAIL lderr_line%0d got=%0h exp=%0h", k, wa_q[x0+k], exp_wa[k]); end
        end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL lderr_err got=%0b exp=1", bus.err); end
        err_line = -1;
    endtask

    task automatic test_random;
        for (int n = 0; n < 10; n++) begin
            int lat, len, r0, a0, w0, x0; logic ok, dir;
            logic [BAW-1:0] b; logic [AAW-1:0] a;
            dir = 1'($urandom); b = BAW'($urandom); a = AAW'($urandom);
            len = $urandom_range(0, 5); err_line = $urandom_range(0, 7);
            aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2); salt = $urandom;
            r0 = ar_q.size(); a0 = aw_q.size(); w0 = w_q.size(); x0 = wa_q.size();
            build_model(dir, b, a, len);
            issue(dir, b, a, LW'(len), lat, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL rnd%0d_timeout got=%0b exp=1", n, ok); end
            total++; if (ar_q.size() - r0 !== exp_ar.size() || aw_q.size() - a0 !== exp_aw.size() || wa_q.size() - x0 !== exp_wa.size()) begin
                bad++; $display("FAIL rnd%0d_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, ar_q.size() - r0, aw_q.size() - a0,
                                 wa_q.size() - x0, exp_ar.size(), exp_aw.size(), exp_wa.size()); end
            for (int k = 0; k < exp_aw.size(); k++) begin
                total++; if (aw_q[a0+k] !== exp_aw[k] || w_q[w0+k] !== exp_w[k]) begin
                    bad++; $display("FAIL rnd%0d_store%0d got=%0h exp=%0h", n, k, aw_q[a0+k], exp_aw[k]); end
            end
            for (int k = 0; k < exp_ar.size(); k++) begin
                total++; if (ar_q[r0+k] !== exp_ar[k]) begin bad++; $display("FAIL rnd%0d_ar%0d got=%0h exp=%0h", n, k, ar_q[r0+k], exp_ar[k]); end
            end
            for (int k = 0; k < exp_wa.size(); k++) begin
                total++; if (wa_q[x0+k] !== exp_wa[k] || wd_q[x0+k] !== exp_wd[k]) begin
                    bad++; $display("FAIL rnd%0d_wr%0d got=%0h exp=%0h", n, k, wa_q[x0+k], exp_wa[k]); end
            end
            total++; if (bus.err !== exp_err) begin bad++; $display("FAIL rnd%0d_err got=%0b exp=%0b", n, bus.err, exp_err); end
        end
        aw_delay = 0; w_delay = 0; err_line = -1;
    endtask

    task automatic test_reset_mid;
        int d0; logic seen;
        aw_delay = 6; d0 = done_cnt; seen = 1'b0;
        @(posedge clk); #2;
        bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b0; bus.cmd_bram_addr = 13'h0055;
        bus.cmd_axi_addr = 24'h00F000; bus.cmd_len = 14'd5;
        @(posedge clk); #2;
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.awvalid) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_awvalid got=%0b exp=1", seen); end
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_cmd_ready got=%0b exp=1", bus.cmd_ready); end
        total++; if ({bus.done, bus.busy, bus.err, bus.we, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 9'd0) begin
            bad++; $display("FAIL rstmid_ctrl got=%b exp=0", {bus.done, bus.busy, bus.err, bus.we, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
        total++; if ({bus.addr, bus.awaddr, bus.wdata} !== '0) begin bad++; $display("FAIL rstmid_addr_data got=%0h exp=0", {bus.addr, bus.awaddr}); end
        rst = 1'b0; aw_delay = 0;
        repeat (10) @(negedge clk);
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL rstmid_done got=%0d exp=%0d", done_cnt, d0); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_bram_addr = '0;
        bus.cmd_axi_addr = '0; bus.cmd_len = '0;
        test_reset;
        test_store_basic;
        test_load_wrap;
        test_len_zero;
        test_aw_delay;
        test_load_err;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
